// File: rtl/bht_access_scheduler_if.sv
// Handshake and RAM bus bundle for the BHT access scheduler.
// slave = scheduler side, master = IF/EX/RAM environment side.
interface bht_access_scheduler_if #(
   parameter int ADDR_W = 5
);
   logic              lkp_valid;
   logic [ADDR_W-1:0] lkp_addr;
   logic              lkp_ready;
   logic              pred_valid;
   logic              pred_taken;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_addr;
   logic              upd_taken;
   logic              upd_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_wdata;
   logic [1:0]        mem_rdata;
   logic              init_done;

   modport slave (
      input  lkp_valid, lkp_addr,
      input  upd_valid, upd_addr, upd_taken,
      input  mem_rdata,
      output lkp_ready, pred_valid, pred_taken,
      output upd_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output init_done
   );

   modport master (
      output lkp_valid, lkp_addr,
      output upd_valid, upd_addr, upd_taken,
      output mem_rdata,
      input  lkp_ready, pred_valid, pred_taken,
      input  upd_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  init_done
   );
endinterface

// File: rtl/bht_access_scheduler.sv
// Single-port 2-bit BHT counter RAM sequencer: init sweep,
// lookup vs. buffered-update arbitration, counter RMW.
module bht_access_scheduler #(
   parameter int         ADDR_W     = 5,
   parameter int         UPD_DEPTH  = 4,
   parameter int         STARVE_MAX = 8,
   parameter logic [1:0] INIT_CNT   = 2'b01
) (
   input  logic clk,
   input  logic arst_n,
   bht_access_scheduler_if.slave bus
);

   localparam int PW = $clog2(UPD_DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      UPD_WR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] init_idx_q, init_idx_d;
   logic              init_done_q, init_done_d;
   logic              pred_valid_q, pred_valid_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;
   logic [ADDR_W-1:0] fifo_addr_q [UPD_DEPTH];
   logic              fifo_taken_q [UPD_DEPTH];

   logic              full, empty, force_upd;
   logic              push, pop, lkp_rdy;
   logic [ADDR_W-1:0] head_addr;
   logic              head_taken;
   logic              mem_en_c, mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [1:0]        mem_wdata_c;

   function automatic logic [1:0] sat_next(
      input logic [1:0] old,
      input logic       taken
   );
      if (taken)
         return (old == 2'b11) ? 2'b11 : old + 2'b01;
      return (old == 2'b00) ? 2'b00 : old - 2'b01;
   endfunction

   assign full       = (count_q == (PW+1)'(UPD_DEPTH));
   assign empty      = (count_q == '0);
   assign force_upd  = full |
                       (!empty && starve_q == SW'(STARVE_MAX));
   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_taken = fifo_taken_q[rd_ptr_q];
   assign lkp_rdy    = (state_q == IDLE) && !force_upd;
   assign push       = bus.upd_valid && bus.upd_ready;
   assign pop        = (state_q == UPD_WR);

   assign bus.lkp_ready  = lkp_rdy;
   assign bus.upd_ready  = init_done_q && !full;
   assign bus.init_done  = init_done_q;
   assign bus.pred_valid = pred_valid_q;
   assign bus.pred_taken = pred_valid_q & bus.mem_rdata[1];
   assign bus.mem_en     = arst_n & mem_en_c;
   assign bus.mem_we     = arst_n & mem_we_c;
   assign bus.mem_addr   = arst_n ? mem_addr_c : '0;
   assign bus.mem_wdata  = arst_n ? mem_wdata_c : '0;

   // FSM next state, arbitration and RAM command
   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      init_done_d  = init_done_q;
      pred_valid_d = 1'b0;
      starve_d     = starve_q;
      mem_en_c     = 1'b0;
      mem_we_c     = 1'b0;
      mem_addr_c   = '0;
      mem_wdata_c  = '0;
      unique case (state_q)
         INIT: begin
            mem_en_c    = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = init_idx_q;
            mem_wdata_c = INIT_CNT;
            init_idx_d  = init_idx_q + ADDR_W'(1);
            if (&init_idx_q) begin
               state_d     = IDLE;
               init_done_d = 1'b1;
            end
         end
         IDLE: begin
            if (force_upd) begin
               mem_en_c   = 1'b1;
               mem_addr_c = head_addr;
               state_d    = UPD_WR;
            end else if (bus.lkp_valid) begin
               mem_en_c     = 1'b1;
               mem_addr_c   = bus.lkp_addr;
               pred_valid_d = 1'b1;
               starve_d     = empty ? '0 : starve_q + SW'(1);
            end else if (!empty) begin
               mem_en_c   = 1'b1;
               mem_addr_c = head_addr;
               state_d    = UPD_WR;
            end
         end
         UPD_WR: begin
            mem_en_c    = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = head_addr;
            mem_wdata_c = sat_next(bus.mem_rdata, head_taken);
            starve_d    = '0;
            state_d     = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   // update FIFO pointer and occupancy bookkeeping
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   // state registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= INIT;
         init_idx_q   <= '0;
         init_done_q  <= 1'b0;
         pred_valid_q <= 1'b0;
         starve_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         init_done_q  <= init_done_d;
         pred_valid_q <= pred_valid_d;
         starve_q     <= starve_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // update FIFO storage
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < UPD_DEPTH; i++) begin
            fifo_addr_q[i]  <= '0;
            fifo_taken_q[i] <= 1'b0;
         end
      end else if (push) begin
         fifo_addr_q[wr_ptr_q]  <= bus.upd_addr;
         fifo_taken_q[wr_ptr_q] <= bus.upd_taken;
      end
   end

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Directed bench for bht_access_scheduler with a
// behavioural single-port counter RAM.
module tb_bht_access_scheduler;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [1:0] ram [32];
   logic [1:0] rdata_q = 2'b00;
   logic [4:0] wl_addr [$];
   logic [1:0] wl_data [$];

   bht_access_scheduler_if #(.ADDR_W(5)) bus ();

   bht_access_scheduler #(
      .ADDR_W    (5),
      .UPD_DEPTH (4),
      .STARVE_MAX(8),
      .INIT_CNT  (2'b01)
   ) dut (
      .clk   (clk),
      .arst_n(arst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = rdata_q;

   // RAM model plus log of post-init writes
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else rdata_q <= ram[bus.mem_addr];
      end
      if (bus.mem_en && bus.mem_we && bus.init_done) begin
         wl_addr.push_back(bus.mem_addr);
         wl_data.push_back(bus.mem_wdata);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_update(input logic [4:0] a, input logic t);
      int w = 0;
      @(negedge clk);
      bus.upd_valid = 1'b1;
      bus.upd_addr  = a;
      bus.upd_taken = t;
      #1;
      while (!bus.upd_ready && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      n_checks++;
      if (w >= 20) begin
         n_fail++;
         $display("FAIL upd_accept: upd_ready got 0 expected 1 within 20 cycles");
      end
      @(negedge clk);
      bus.upd_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [4:0] a, input logic exp);
      int w = 0;
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = a;
      #1;
      while (!bus.lkp_ready && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      @(negedge clk);
      bus.lkp_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.pred_valid, bus.pred_taken} !== {1'b1, exp}) begin
         n_fail++;
         $display("FAIL lookup_%0d: pred v/t got %b%b expected 1%b",
                  a, bus.pred_valid, bus.pred_taken, exp);
      end
   endtask

   task automatic test_reset();
      bus.lkp_valid = 1'b0;
      bus.lkp_addr  = '0;
      bus.upd_valid = 1'b0;
      bus.upd_addr  = '0;
      bus.upd_taken = 1'b0;
      arst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({bus.lkp_ready, bus.pred_valid, bus.pred_taken,
           bus.upd_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_hs: got %b%b%b%b expected 0000",
                  bus.lkp_ready, bus.pred_valid, bus.pred_taken,
                  bus.upd_ready);
      end
      n_checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
          !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_mem: got %b%b %0d %b expected 00 0 00",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      n_checks++;
      if (bus.init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_init_done: got %b expected 0",
                  bus.init_done);
      end
   endtask

   task automatic test_init();
      logic [11:0] got, exp;
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         got = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.lkp_ready, bus.upd_ready, bus.init_done};
         exp = {1'b1, 1'b1, 5'(k), 2'b01, 1'b0, 1'b0, 1'b0};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL init_wr_%0d: got %b expected %b", k, got, exp);
         end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.init_done, bus.mem_en, bus.lkp_ready, bus.upd_ready}
          !== 4'b1011) begin
         n_fail++;
         $display("FAIL init_done_rise: got %b%b%b%b expected 1011",
                  bus.init_done, bus.mem_en, bus.lkp_ready,
                  bus.upd_ready);
      end
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = 5'd7;
      #1;
      n_checks++;
      if ({bus.lkp_ready, bus.mem_en, bus.mem_we, bus.mem_addr}
          !== {3'b110, 5'd7}) begin
         n_fail++;
         $display("FAIL lkp7_issue: got %b%b%b %0d expected 110 7",
                  bus.lkp_ready, bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      @(negedge clk);
      bus.lkp_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.pred_valid, bus.pred_taken} !== 2'b10) begin
         n_fail++;
         $display("FAIL lkp7_pred: got %b%b expected 10",
                  bus.pred_valid, bus.pred_taken);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.pred_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lkp7_pulse: pred_valid got %b expected 0",
                  bus.pred_valid);
      end
   endtask

   task automatic test_update_taken();
      wl_addr.delete();
      wl_data.delete();
      do_update(5'd3, 1'b1);
      do_update(5'd3, 1'b1);
      repeat (8) @(negedge clk);
      n_checks++;
      if (wl_addr.size() !== 2) begin
         n_fail++;
         $display("FAIL upd3_count: got %0d writes expected 2",
                  wl_addr.size());
      end else begin
         n_checks++;
         if ({wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]}
             !== {5'd3, 2'b10, 5'd3, 2'b11}) begin
            n_fail++;
            $display("FAIL upd3_seq: got %0d:%b %0d:%b expected 3:10 3:11",
                     wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]);
         end
      end
      do_lookup(5'd3, 1'b1);
   endtask

   task automatic test_saturate();
      logic [1:0] exp [4];
      exp[0] = 2'b10;
      exp[1] = 2'b01;
      exp[2] = 2'b00;
      exp[3] = 2'b00;
      do_update(5'd9, 1'b1);
      do_update(5'd9, 1'b1);
      repeat (8) @(negedge clk);
      wl_addr.delete();
      wl_data.delete();
      for (int i = 0; i < 4; i++) do_update(5'd9, 1'b0);
      repeat (10) @(negedge clk);
      n_checks++;
      if (wl_addr.size() !== 4) begin
         n_fail++;
         $display("FAIL sat9_count: got %0d writes expected 4",
                  wl_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({wl_addr[i], wl_data[i]} !== {5'd9, exp[i]}) begin
               n_fail++;
               $display("FAIL sat9_wr%0d: got %0d:%b expected 9:%b",
                        i, wl_addr[i], wl_data[i], exp[i]);
            end
         end
      end
      do_lookup(5'd9, 1'b0);
   endtask

   task automatic test_starvation();
      int grants = 0;
      repeat (4) @(negedge clk);
      @(negedge clk);
      bus.lkp_valid = 1'b1;
      bus.lkp_addr  = 5'd1;
      bus.upd_valid = 1'b1;
      bus.upd_addr  = 5'd5;
      bus.upd_taken = 1'b1;
      #1;
      n_checks++;
      if ({bus.lkp_ready, bus.upd_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL starve_start: got %b%b expected 11",
                  bus.lkp_ready, bus.upd_ready);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         bus.upd_valid = 1'b0;
         #1;
         if (bus.lkp_ready) grants++;
         n_checks++;
         if (bus.pred_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pred_%0d: pred_valid got %b expected 1",
                     i, bus.pred_valid);
         end
      end
      n_checks++;
      if (grants !== 8) begin
         n_fail++;
         $display("FAIL starve_grants: got %0d expected 8", grants);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.lkp_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
           bus.pred_valid} !== {3'b010, 5'd5, 1'b1}) begin
         n_fail++;
         $display("FAIL starve_rd: got %b%b%b %0d %b expected 010 5 1",
                  bus.lkp_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
                  bus.pred_valid);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.lkp_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
           bus.mem_wdata} !== {3'b011, 5'd5, 2'b10}) begin
         n_fail++;
         $display("FAIL starve_wr: got %b%b%b %0d %b expected 011 5 10",
                  bus.lkp_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
                  bus.mem_wdata);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.lkp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_resume: lkp_ready got %b expected 1",
                  bus.lkp_ready);
      end
      @(negedge clk);
      bus.lkp_valid = 1'b0;
   endtask

   task automatic test_fifo_full();
      repeat (3) @(negedge clk);
      wl_addr.delete();
      wl_data.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.lkp_valid = 1'b1;
         bus.lkp_addr  = 5'd2;
         bus.upd_valid = 1'b1;
         bus.upd_addr  = 5'(10 + i);
         bus.upd_taken = 1'b1;
         #1;
         n_checks++;
         if ({bus.upd_ready, bus.lkp_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_push%0d: got %b%b expected 11",
                     i, bus.upd_ready, bus.lkp_ready);
         end
      end
      @(negedge clk);
      bus.upd_addr = 5'd14;
      #1;
      n_checks++;
      if ({bus.upd_ready, bus.lkp_ready, bus.mem_en, bus.mem_we,
           bus.mem_addr} !== {4'b0010, 5'd10}) begin
         n_fail++;
         $display("FAIL full_force: got %b%b%b%b %0d expected 0010 10",
                  bus.upd_ready, bus.lkp_ready, bus.mem_en, bus.mem_we,
                  bus.mem_addr);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.upd_ready, bus.lkp_ready, bus.mem_we, bus.mem_addr}
          !== {3'b001, 5'd10}) begin
         n_fail++;
         $display("FAIL full_pop: got %b%b%b %0d expected 001 10",
                  bus.upd_ready, bus.lkp_ready, bus.mem_we,
                  bus.mem_addr);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.upd_ready, bus.lkp_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL full_reopen: got %b%b expected 11",
                  bus.upd_ready, bus.lkp_ready);
      end
      @(negedge clk);
      bus.upd_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.upd_ready, bus.lkp_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL full_again: got %b%b expected 00",
                  bus.upd_ready, bus.lkp_ready);
      end
      @(negedge clk);
      bus.lkp_valid = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (wl_addr.size() !== 5) begin
         n_fail++;
         $display("FAIL full_drain: got %0d writes expected 5",
                  wl_addr.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({wl_addr[i], wl_data[i]} !== {5'(10 + i), 2'b10}) begin
               n_fail++;
               $display("FAIL full_wr%0d: got %0d:%b expected %0d:10",
                        i, wl_addr[i], wl_data[i], 10 + i);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] outs;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.upd_valid = 1'b1;
         bus.upd_addr  = 5'(20 + i);
         bus.upd_taken = 1'b1;
      end
      @(negedge clk);
      bus.upd_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.mem_en, bus.mem_we} !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_updwr: got %b%b expected 11",
                  bus.mem_en, bus.mem_we);
      end
      arst_n = 1'b0;
      #1;
      outs = {bus.lkp_ready, bus.pred_valid, bus.pred_taken,
              bus.upd_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
              bus.mem_wdata, bus.init_done};
      n_checks++;
      if (outs !== 14'd0) begin
         n_fail++;
         $display("FAIL mid_rst_outs: got %b expected 0", outs);
      end
      wl_addr.delete();
      wl_data.delete();
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      #1;
      n_checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.init_done, bus.upd_ready}
          !== {2'b11, 5'd0, 2'b01, 2'b00}) begin
         n_fail++;
         $display("FAIL mid_sweep0: got %b%b %0d %b %b%b expected 11 0 01 00",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                  bus.init_done, bus.upd_ready);
      end
      repeat (31) @(negedge clk);
      #1;
      n_checks++;
      if ({bus.mem_we, bus.mem_addr, bus.init_done}
          !== {1'b1, 5'd31, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_sweep31: got %b %0d %b expected 1 31 0",
                  bus.mem_we, bus.mem_addr, bus.init_done);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.init_done, bus.upd_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_init_done: got %b%b expected 11",
                  bus.init_done, bus.upd_ready);
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (wl_addr.size() !== 0) begin
         n_fail++;
         $display("FAIL mid_stale: got %0d writes expected 0",
                  wl_addr.size());
      end
      do_lookup(5'd20, 1'b0);
   endtask

   initial begin
      test_reset();
      test_init();
      test_update_taken();
      test_saturate();
      test_starvation();
      test_fifo_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
